// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared pipeline constants (reset PC, bus widths); IF_ADEF_EN widens the IF->ID bus by the adef bit
package cpu_defs;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam int BR_BUS_WD = 33;
`ifdef IF_ADEF_EN
  localparam int FS_TO_DS_BUS_WD = 65;
`else
  localparam int FS_TO_DS_BUS_WD = 64;
`endif
endpackage

// File: rtl/if_inst_buf.sv
// if_inst_buf: one-entry instruction buffer holding SRAM read data while ID stalls
module if_inst_buf #(
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fs_valid,
  input  logic              ds_allowin,
  input  logic              cancel,
  input  logic              handoff,
  input  logic [INST_W-1:0] rdata,
  output logic [INST_W-1:0] fs_inst
);
  logic              buf_valid;
  logic [INST_W-1:0] inst_buf;
  // capture the one-shot SRAM data when ID stalls; drop it on handoff or wrong-path cancel
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      buf_valid <= 1'b0;
      inst_buf  <= '0;
    end else if (handoff | cancel) begin
      buf_valid <= 1'b0;
    end else if (fs_valid & !ds_allowin & !buf_valid) begin
      buf_valid <= 1'b1;
      inst_buf  <= rdata;
    end
  assign fs_inst = buf_valid ? inst_buf : rdata;
endmodule

// File: rtl/if_stage.sv
// if_stage: LoongArch IF stage (next-PC select, PC register, inst-SRAM request, buffered handoff to ID); IF_ADEF_EN adds adef
module if_stage
  import cpu_defs::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [PC_W-1:0]            inst_sram_addr,
  output logic [INST_W-1:0]          inst_sram_wdata,
  input  logic [INST_W-1:0]          inst_sram_rdata
);
  logic              to_fs_valid, fs_valid, br_pend, br_taken;
  logic              fs_allowin, issue, handoff;
  logic [PC_W-1:0]   fs_pc, pend_target, br_target, seq_pc, nextpc;
  logic [INST_W-1:0] fs_inst;
  assign {br_taken, br_target} = br_bus;
  assign seq_pc         = fs_pc + PC_W'(4);
  assign nextpc         = br_taken ? br_target : br_pend ? pend_target : seq_pc;
  assign fs_allowin     = !fs_valid | ds_allowin;
  assign issue          = to_fs_valid & fs_allowin;
  assign fs_to_ds_valid = fs_valid & !br_taken;
  assign handoff        = fs_to_ds_valid & ds_allowin;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = '0;
  // pre-IF becomes live one edge after reset release and never drops
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) to_fs_valid <= 1'b0;
    else         to_fs_valid <= 1'b1;
  // IF PC/valid advance on issue; a cancel kills the wrong-path instruction unless a new one enters
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (issue) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
    end else if (br_taken) begin
      fs_valid <= 1'b0;
    end
  // remember a redirect that arrived while IF could not accept a new fetch
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      br_pend     <= 1'b0;
      pend_target <= '0;
    end else if (issue) begin
      br_pend <= 1'b0;
    end else if (br_taken) begin
      br_pend     <= 1'b1;
      pend_target <= br_target;
    end
  if_inst_buf #(.INST_W(INST_W)) u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .fs_valid  (fs_valid),
    .ds_allowin(ds_allowin),
    .cancel    (br_taken),
    .handoff   (handoff),
    .rdata     (inst_sram_rdata),
    .fs_inst   (fs_inst)
  );
`ifdef IF_ADEF_EN
  logic fs_adef;
  logic adef;
  assign adef           = |nextpc[1:0];
  assign inst_sram_en   = issue & !adef;
  assign inst_sram_addr = to_fs_valid ? nextpc : '0;
  assign fs_to_ds_bus   = fs_valid ? {fs_adef, fs_pc, fs_adef ? {INST_W{1'b0}} : fs_inst} : '0;
  // misaligned fetches still advance IF but carry adef instead of SRAM data
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)    fs_adef <= 1'b0;
    else if (issue) fs_adef <= adef;
`else
  assign inst_sram_en   = issue;
  assign inst_sram_addr = to_fs_valid ? {nextpc[PC_W-1:2], 2'b00} : '0;
  assign fs_to_ds_bus   = fs_valid ? {fs_pc, fs_inst} : '0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch sequencing, stall buffering, branch redirect/pend and reset for if_stage
module tb_if_stage;
  import cpu_defs::*;
  logic                       clk = 1'b0;
  logic                       resetn;
  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_en;
  logic [3:0]                 inst_sram_we;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;
  logic [31:0]                inst_sram_rdata;
  int total = 0;
  int bad = 0;

  if_stage dut (
    .clk            (clk),
    .resetn         (resetn),
    .ds_allowin     (ds_allowin),
    .br_bus         (br_bus),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: word at address A reads as A+0x10000000; no request leaves garbage on the bus
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? inst_sram_addr + 32'h1000_0000 : 32'hbad0_bad0;

  function automatic logic [FS_TO_DS_BUS_WD-1:0] bus_of(input logic [31:0] pc, input logic [31:0] inst);
    return FS_TO_DS_BUS_WD'({pc, inst});
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    ds_allowin = 1'b1;
    br_bus = '0;
    #2;
    chk("rst_valid", 96'(fs_to_ds_valid), 96'd0);
    chk("rst_en", 96'(inst_sram_en), 96'd0);
    chk("rst_addr", 96'(inst_sram_addr), 96'd0);
    chk("rst_bus", 96'(fs_to_ds_bus), 96'd0);
    chk("rst_we_wdata", 96'({inst_sram_we, inst_sram_wdata}), 96'd0);
    cyc();
    resetn = 1'b1;
    #1 chk("pre_en", 96'(inst_sram_en), 96'd0);
    // reset release, streaming fetch
    cyc(); #1;
    chk("a_en", 96'(inst_sram_en), 96'd1);
    chk("a_addr", 96'(inst_sram_addr), 96'h1c00_0000);
    chk("a_valid", 96'(fs_to_ds_valid), 96'd0);
    cyc(); #1;
    chk("b_valid", 96'(fs_to_ds_valid), 96'd1);
    chk("b_bus", 96'(fs_to_ds_bus), 96'(bus_of(32'h1c00_0000, 32'h2c00_0000)));
    chk("b_addr", 96'(inst_sram_addr), 96'h1c00_0004);
    // ID stall for three cycles holding 1c000004
    cyc();
    ds_allowin = 1'b0;
    #1;
    chk("c_valid", 96'(fs_to_ds_valid), 96'd1);
    chk("c_bus", 96'(fs_to_ds_bus), 96'(bus_of(32'h1c00_0004, 32'h2c00_0004)));
    chk("c_en", 96'(inst_sram_en), 96'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("stall_bus", 96'(fs_to_ds_bus), 96'(bus_of(32'h1c00_0004, 32'h2c00_0004)));
      chk("stall_en", 96'(inst_sram_en), 96'd0);
    end
    cyc();
    ds_allowin = 1'b1;
    #1;
    chk("f_valid", 96'(fs_to_ds_valid), 96'd1);
    chk("f_bus", 96'(fs_to_ds_bus), 96'(bus_of(32'h1c00_0004, 32'h2c00_0004)));
    chk("f_en", 96'(inst_sram_en), 96'd1);
    chk("f_addr", 96'(inst_sram_addr), 96'h1c00_0008);
    // branch while IF holds 1c000008
    cyc();
    br_bus = {1'b1, 32'h1c00_0100};
    #1;
    chk("g_valid", 96'(fs_to_ds_valid), 96'd0);
    chk("g_en", 96'(inst_sram_en), 96'd1);
    chk("g_addr", 96'(inst_sram_addr), 96'h1c00_0100);
    cyc();
    br_bus = '0;
    ds_allowin = 1'b0;
    #1;
    chk("h_valid", 96'(fs_to_ds_valid), 96'd1);
    chk("h_bus", 96'(fs_to_ds_bus), 96'(bus_of(32'h1c00_0100, 32'h2c00_0100)));
    chk("h_en", 96'(inst_sram_en), 96'd0);
    // branch with a full buffer and ID stalled
    cyc();
    br_bus = {1'b1, 32'h1c00_0200};
    #1;
    chk("i_valid", 96'(fs_to_ds_valid), 96'd0);
    chk("i_en", 96'(inst_sram_en), 96'd0);
    chk("i_bus_buf", 96'(fs_to_ds_bus), 96'(bus_of(32'h1c00_0100, 32'h2c00_0100)));
    cyc();
    br_bus = '0;
    ds_allowin = 1'b1;
    #1;
    chk("j_valid", 96'(fs_to_ds_valid), 96'd0);
    chk("j_en", 96'(inst_sram_en), 96'd1);
    chk("j_addr", 96'(inst_sram_addr), 96'h1c00_0200);
    cyc();
    ds_allowin = 1'b0;
    #1;
    chk("k_valid", 96'(fs_to_ds_valid), 96'd1);
    chk("k_bus", 96'(fs_to_ds_bus), 96'(bus_of(32'h1c00_0200, 32'h2c00_0200)));
    // reset in the middle of a buffered stall
    cyc();
    resetn = 1'b0;
    #1;
    chk("l_valid", 96'(fs_to_ds_valid), 96'd0);
    chk("l_en", 96'(inst_sram_en), 96'd0);
    chk("l_addr", 96'(inst_sram_addr), 96'd0);
    chk("l_bus", 96'(fs_to_ds_bus), 96'd0);
    cyc();
    resetn = 1'b1;
    ds_allowin = 1'b1;
    #1 chk("m_en", 96'(inst_sram_en), 96'd0);
    cyc(); #1;
    chk("n_en", 96'(inst_sram_en), 96'd1);
    chk("n_addr", 96'(inst_sram_addr), 96'h1c00_0000);
    cyc(); #1;
    chk("o_valid", 96'(fs_to_ds_valid), 96'd1);
    chk("o_bus", 96'(fs_to_ds_bus), 96'(bus_of(32'h1c00_0000, 32'h2c00_0000)));
`ifdef IF_ADEF_EN
    // misaligned branch target raises adef without an SRAM request
    cyc();
    br_bus = {1'b1, 32'h1c00_0102};
    #1;
    chk("p_en", 96'(inst_sram_en), 96'd0);
    chk("p_valid", 96'(fs_to_ds_valid), 96'd0);
    cyc();
    br_bus = '0;
    #1;
    chk("q_valid", 96'(fs_to_ds_valid), 96'd1);
    chk("q_bus", 96'(fs_to_ds_bus), 96'({1'b1, 32'h1c00_0102, 32'h0}));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
